tlb_refill_ctrl: RTL and testbench

TLB_REFILL_CTRL -- requirements
Module: tlb_refill_ctrl

---
 rtl/tlb_pkg.sv | 28 ++
 rtl/tlb_plru.sv | 35 +++
 rtl/tlb_refill_ctrl.sv | 104 ++++++++++
 tb/tb_tlb_refill_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared types and sizes for the TLB refill controller and its PLRU tree.
package tlb_pkg;

  localparam int unsigned NUM_ENTRIES = 8;
  localparam int unsigned IDX_W       = 3;
  localparam int unsigned VPN_W       = 27;
  localparam int unsigned ASID_W      = 7;
  localparam int unsigned TAG_W       = 34;
  localparam int unsigned PLRU_W      = 7;

  typedef enum logic [1:0] {
    ST_READY    = 2'd0,
    ST_REQUEST  = 2'd1,
    ST_WAIT     = 2'd2,
    ST_WAIT_INV = 2'd3
  } state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_ENTRIES-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tlb_plru.sv
// 8-way tree pseudo-LRU: node bits point toward the next victim, touches point away.
module tlb_plru
  import tlb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             touch_i,
  input  logic [IDX_W-1:0] touch_idx_i,
  output logic [IDX_W-1:0] victim_c_o
);

  logic [PLRU_W-1:0] plru_q, plru_d;
  logic              vic_hi, vic_mid;

  always_comb begin
    plru_d = plru_q;
    if (touch_i) begin
      plru_d[0]                                        = ~touch_idx_i[2];
      plru_d[3'd1 + {2'b00, touch_idx_i[2]}]           = ~touch_idx_i[1];
      plru_d[3'd3 + {1'b0, touch_idx_i[2:1]}]          = ~touch_idx_i[0];
    end
  end

  always_comb begin
    vic_hi     = plru_q[0];
    vic_mid    = vic_hi ? plru_q[2] : plru_q[1];
    victim_c_o = {vic_hi, vic_mid, plru_q[3'd3 + {1'b0, vic_hi, vic_mid}]};
  end

  always_ff @(posedge clk) begin
    if (reset) plru_q <= '0;
    else       plru_q <= plru_d;
  end

endmodule

// File: rtl/tlb_refill_ctrl.sv
// TLB miss handling: latches the missing VPN, drives the PTW handshake and writes back the refill.
module tlb_refill_ctrl
  import tlb_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   io_req_valid,
  input  logic [VPN_W-1:0]       io_req_bits_vpn,
  input  logic [ASID_W-1:0]      io_ptw_ptbr_asid,
  input  logic                   tlb_miss,
  input  logic [NUM_ENTRIES-1:0] hits,
  output logic                   io_req_ready,
  output logic                   io_ptw_req_valid,
  input  logic                   io_ptw_req_ready,
  output logic [VPN_W-1:0]       io_ptw_req_bits_addr,
  input  logic                   io_ptw_resp_valid,
  input  logic                   io_ptw_resp_bits_error,
  input  logic                   io_invalidate,
  output logic [NUM_ENTRIES-1:0] valid,
  output logic                   refill_we,
  output logic [IDX_W-1:0]       refill_idx,
  output logic [TAG_W-1:0]       refill_tag,
  output logic                   io_resp_error
);

  state_e                 state_q;
  logic [VPN_W-1:0]       vpn_q;
  logic [ASID_W-1:0]      asid_q;
  logic [IDX_W-1:0]       victim_q;
  logic [NUM_ENTRIES-1:0] valid_q;

  logic             in_wait_resp;
  logic             hit_touch;
  logic             plru_touch;
  logic [IDX_W-1:0] plru_touch_idx;
  logic [IDX_W-1:0] plru_victim;
  logic [IDX_W-1:0] victim_sel;

  assign io_req_ready         = (state_q == ST_READY);
  assign io_ptw_req_valid     = (state_q == ST_REQUEST);
  assign io_ptw_req_bits_addr = vpn_q;
  assign valid                = valid_q;

  // Response outcome is decided in the response cycle; reset and invalidate both veto it.
  always_comb begin
    in_wait_resp  = ~reset & (state_q == ST_WAIT) & io_ptw_resp_valid & ~io_invalidate;
    refill_we     = in_wait_resp & ~io_ptw_resp_bits_error;
    io_resp_error = in_wait_resp & io_ptw_resp_bits_error;
    refill_idx    = victim_q;
    refill_tag    = {asid_q, vpn_q};
  end

  always_comb begin
    hit_touch      = (state_q == ST_READY) & io_req_valid & ~tlb_miss & (|hits);
    plru_touch     = hit_touch | refill_we;
    plru_touch_idx = refill_we ? victim_q : lowest_set(hits);
    victim_sel     = (&valid_q) ? plru_victim : lowest_set(~valid_q);
  end

  tlb_plru u_plru (
    .clk         (clk),
    .reset       (reset),
    .touch_i     (plru_touch),
    .touch_idx_i (plru_touch_idx),
    .victim_c_o  (plru_victim)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_READY;
      vpn_q    <= '0;
      asid_q   <= '0;
      victim_q <= '0;
      valid_q  <= '0;
    end else begin
      if (io_invalidate)  valid_q             <= '0;
      else if (refill_we) valid_q[victim_q]   <= 1'b1;

      case (state_q)
        ST_READY: begin
          if (io_req_valid && tlb_miss && !io_invalidate) begin
            vpn_q    <= io_req_bits_vpn;
            asid_q   <= io_ptw_ptbr_asid;
            victim_q <= victim_sel;
            state_q  <= ST_REQUEST;
          end
        end
        ST_REQUEST: begin
          if (io_invalidate)         state_q <= io_ptw_req_ready ? ST_WAIT_INV : ST_READY;
          else if (io_ptw_req_ready) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (io_ptw_resp_valid)  state_q <= ST_READY;
          else if (io_invalidate) state_q <= ST_WAIT_INV;
        end
        ST_WAIT_INV: begin
          if (io_ptw_resp_valid) state_q <= ST_READY;
        end
        default: state_q <= ST_READY;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// Directed bench for tlb_refill_ctrl: cold fill, PLRU victims, stall, fault, invalidate, reset.
module tb_tlb_refill_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        io_req_valid;
  logic [26:0] io_req_bits_vpn;
  logic [6:0]  io_ptw_ptbr_asid;
  logic        tlb_miss;
  logic [7:0]  hits;
  logic        io_req_ready;
  logic        io_ptw_req_valid;
  logic        io_ptw_req_ready;
  logic [26:0] io_ptw_req_bits_addr;
  logic        io_ptw_resp_valid;
  logic        io_ptw_resp_bits_error;
  logic        io_invalidate;
  logic [7:0]  valid;
  logic        refill_we;
  logic [2:0]  refill_idx;
  logic [33:0] refill_tag;
  logic        io_resp_error;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [6:0] ASID = 7'h15;

  always #5 clk = ~clk;

  tlb_refill_ctrl dut (
    .clk                    (clk),
    .reset                  (reset),
    .io_req_valid           (io_req_valid),
    .io_req_bits_vpn        (io_req_bits_vpn),
    .io_ptw_ptbr_asid       (io_ptw_ptbr_asid),
    .tlb_miss               (tlb_miss),
    .hits                   (hits),
    .io_req_ready           (io_req_ready),
    .io_ptw_req_valid       (io_ptw_req_valid),
    .io_ptw_req_ready       (io_ptw_req_ready),
    .io_ptw_req_bits_addr   (io_ptw_req_bits_addr),
    .io_ptw_resp_valid      (io_ptw_resp_valid),
    .io_ptw_resp_bits_error (io_ptw_resp_bits_error),
    .io_invalidate          (io_invalidate),
    .valid                  (valid),
    .refill_we              (refill_we),
    .refill_idx             (refill_idx),
    .refill_tag             (refill_tag),
    .io_resp_error          (io_resp_error)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a miss, walk REQUEST (with optional stall) until the PTW accepts; ends in WAIT.
  task automatic miss_start(input logic [26:0] vpn, input int stall);
    io_req_valid = 1'b1; tlb_miss = 1'b1; io_req_bits_vpn = vpn;
    tick();
    io_req_valid = 1'b0; tlb_miss = 1'b0;
    for (int i = 0; i < stall; i++) begin
      #1;
      chk("stall_req_valid", 64'(io_ptw_req_valid), 64'd1);
      chk("stall_addr", 64'(io_ptw_req_bits_addr), 64'(vpn));
      chk("stall_req_ready", 64'(io_req_ready), 64'd0);
      tick();
    end
    io_ptw_req_ready = 1'b1;
    #1;
    chk("ptw_req_valid", 64'(io_ptw_req_valid), 64'd1);
    chk("ptw_addr", 64'(io_ptw_req_bits_addr), 64'(vpn));
    tick();
    io_ptw_req_ready = 1'b0;
  endtask

  // Deliver a PTW response in WAIT and check the refill / error outputs.
  task automatic resp_step(input logic err, input logic exp_we, input logic [2:0] exp_idx,
                           input logic [26:0] vpn);
    io_ptw_resp_valid = 1'b1; io_ptw_resp_bits_error = err;
    #1;
    chk("refill_we", 64'(refill_we), 64'(exp_we));
    chk("resp_error", 64'(io_resp_error), 64'(err));
    if (exp_we) begin
      chk("refill_idx", 64'(refill_idx), 64'(exp_idx));
      chk("refill_tag", 64'(refill_tag), 64'({ASID, vpn}));
    end
    tick();
    io_ptw_resp_valid = 1'b0; io_ptw_resp_bits_error = 1'b0;
    #1;
    chk("ready_after_resp", 64'(io_req_ready), 64'd1);
    chk("resp_error_gone", 64'(io_resp_error), 64'd0);
  endtask

  task automatic hit(input logic [7:0] h);
    io_req_valid = 1'b1; tlb_miss = 1'b0; hits = h;
    tick();
    io_req_valid = 1'b0; hits = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; io_req_valid = 1'b0; io_req_bits_vpn = '0; io_ptw_ptbr_asid = ASID;
    tlb_miss = 1'b0; hits = 8'h00; io_ptw_req_ready = 1'b0; io_ptw_resp_valid = 1'b0;
    io_ptw_resp_bits_error = 1'b0; io_invalidate = 1'b0;
    tick(); tick();
    #1;
    chk("rst_req_ready", 64'(io_req_ready), 64'd1);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_ptw_valid", 64'(io_ptw_req_valid), 64'd0);
    chk("rst_refill_we", 64'(refill_we), 64'd0);
    chk("rst_resp_error", 64'(io_resp_error), 64'd0);
    reset = 1'b0;
    tick();

    // Cold fill: lowest invalid entry each time; PLRU returns to all-zero afterwards.
    for (int i = 0; i < 8; i++) begin
      miss_start(27'h100 + 27'(i), 0);
      resp_step(1'b0, 1'b1, 3'(i), 27'h100 + 27'(i));
    end
    chk("cold_valid", 64'(valid), 64'hFF);

    // PLRU=0, hit way 0 -> victim 4.
    hit(8'h01);
    miss_start(27'h200, 0);
    resp_step(1'b0, 1'b1, 3'd4, 27'h200);

    // Multi-hit 0x11 touches way 0 (lowest) -> victim 6; touching 4 would give way 0-3.
    hit(8'h11);
    miss_start(27'h300, 0);
    resp_step(1'b0, 1'b1, 3'd6, 27'h300);

    // PTW stall for 5 cycles; victim 2 from current PLRU state.
    miss_start(27'h400, 5);
    resp_step(1'b0, 1'b1, 3'd2, 27'h400);

    // Faulting walk: error pulse, no write, valid unchanged.
    miss_start(27'h450, 0);
    resp_step(1'b1, 1'b0, 3'd0, 27'h450);
    chk("fault_valid", 64'(valid), 64'hFF);

    // Invalidate during WAIT, then a late response.
    miss_start(27'h500, 0);
    io_invalidate = 1'b1;
    tick();
    io_invalidate = 1'b0;
    #1;
    chk("inv_wait_valid", 64'(valid), 64'd0);
    chk("inv_wait_busy", 64'(io_req_ready), 64'd0);
    resp_step(1'b0, 1'b0, 3'd0, 27'h500);
    chk("inv_wait_valid2", 64'(valid), 64'd0);

    // Refill entry 0, then invalidate and response in the same cycle.
    miss_start(27'h601, 0);
    resp_step(1'b0, 1'b1, 3'd0, 27'h601);
    chk("one_valid", 64'(valid), 64'h01);
    miss_start(27'h602, 0);
    io_invalidate = 1'b1; io_ptw_resp_valid = 1'b1;
    #1;
    chk("inv_resp_we", 64'(refill_we), 64'd0);
    tick();
    io_invalidate = 1'b0; io_ptw_resp_valid = 1'b0;
    #1;
    chk("inv_resp_valid", 64'(valid), 64'd0);
    chk("inv_resp_ready", 64'(io_req_ready), 64'd1);

    // Invalidate in REQUEST without fire returns to READY.
    io_req_valid = 1'b1; tlb_miss = 1'b1; io_req_bits_vpn = 27'h650;
    tick();
    io_req_valid = 1'b0; tlb_miss = 1'b0; io_invalidate = 1'b1;
    tick();
    io_invalidate = 1'b0;
    #1;
    chk("req_inv_ready", 64'(io_req_ready), 64'd1);
    chk("req_inv_ptw_valid", 64'(io_ptw_req_valid), 64'd0);

    // Reset while in WAIT; later response is ignored.
    miss_start(27'h700, 0);
    resp_step(1'b0, 1'b1, 3'd0, 27'h700);
    miss_start(27'h701, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rstwait_ready", 64'(io_req_ready), 64'd1);
    chk("rstwait_valid", 64'(valid), 64'd0);
    io_ptw_resp_valid = 1'b1;
    #1;
    chk("rstwait_we", 64'(refill_we), 64'd0);
    chk("rstwait_err", 64'(io_resp_error), 64'd0);
    tick();
    io_ptw_resp_valid = 1'b0;
    #1;
    chk("rstwait_ready2", 64'(io_req_ready), 64'd1);
    chk("rstwait_valid2", 64'(valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
